// File: rtl/tick_pkg.sv
// Shared definitions for the phased tick generator.
// FSM state encoding and default divisor / phase count.
package tick_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int TICK_DEF_DIV = 62;
    localparam int TICK_NPHASE  = 4;

endpackage

// File: rtl/tick_gen_phased.sv
// Phased tick generator: NPHASE phase pulses per period,
// plus a period tick on the last phase. Divisor is shadowed.
module tick_gen_phased
    import tick_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int NPHASE  = TICK_NPHASE,
    parameter int DEF_DIV = TICK_DEF_DIV,
    localparam int IW     = $clog2(NPHASE)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             phase_tick,
    output logic [IW-1:0]    phase_idx,
    output logic             tick,
    output logic             busy
);

    localparam logic [IW-1:0] LAST = IW'(NPHASE - 1);

    state_t state;
    state_t nxt;

    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] d_eff;
    logic [IW-1:0]    pidx;
    logic             start;
    logic             run;
    logic             term;

    // A zero divisor behaves as one clock per phase.
    assign d_eff = (div_act == '0) ? DIV_W'(1) : div_act;
    assign term  = (cnt == d_eff - DIV_W'(1));
    assign start = (state == IDLE) && en;
    assign run   = (state == RUN) && en;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nxt;
    end

    // Next-state: enable alone moves between IDLE and RUN.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (en)  nxt = RUN;
            RUN:  if (!en) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Phase counter, shadow divisor and registered pulse outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            pidx       <= '0;
            div_act    <= DIV_W'(DEF_DIV);
            phase_tick <= 1'b0;
            phase_idx  <= '0;
            tick       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            phase_tick <= 1'b0;
            tick       <= 1'b0;
            busy       <= (nxt == RUN);
            if (start) begin
                cnt     <= '0;
                pidx    <= '0;
                div_act <= div;
            end else if (!run) begin
                cnt  <= '0;
                pidx <= '0;
            end else if (restart) begin
                // Restart wins over a coincident terminal count.
                cnt     <= '0;
                pidx    <= '0;
                div_act <= div;
            end else if (term) begin
                cnt        <= '0;
                phase_tick <= 1'b1;
                phase_idx  <= pidx;
                tick       <= (pidx == LAST);
                if (pidx == LAST) begin
                    pidx    <= '0;
                    div_act <= div;
                end else begin
                    pidx <= pidx + IW'(1);
                end
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: doc/tick_gen_phased.md
TICK_GEN_PHASED -- requirements
Module: tick_gen_phased

Interface
REQ-001 SHALL have parameter DIV_W, default 16, meaning width of the per-phase divisor.
REQ-002 SHALL have parameter NPHASE, default 4, meaning the number of phase pulses per output period (legal range 2..16).
REQ-003 SHALL have parameter DEF_DIV, default 62, meaning the divisor loaded at reset (100 MHz / (4*62) ≈ 403 kHz).
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  run enable; low holds the block idle.
REQ-007 restart  input  1  single-cycle synchronous request to restart the period from phase 0.
REQ-008 div  input  DIV_W  clocks per phase, sampled only at reload points.
REQ-009 phase_tick  output  1  one-clk pulse at the end of each phase.
REQ-010 phase_idx  output  $clog2(NPHASE)  index of the phase that just ended, valid while phase_tick=1.
REQ-011 tick  output  1  one-clk pulse at the end of each full period (last phase).
REQ-012 busy  output  1  high while in RUN state.

Function
REQ-013 SHALL implement a two-state FSM: IDLE, RUN; IDLE->RUN on en=1; RUN->IDLE on en=0.
REQ-014 SHALL hold an effective divisor D = max(div_act,1), where div_act is a shadow register; div=0 behaves as 1.
REQ-015 SHALL load div_act from div on IDLE->RUN, on every tick, and on accepted restart; changes to div at any other time have no effect.
REQ-016 With en first sampled high at edge E0, first phase_tick SHALL rise at edge E0+D, then every D clocks while en stays high.
REQ-017 phase_idx SHALL be 0 on the first pulse, increment by 1 per pulse, and wrap from NPHASE-1 to 0.
REQ-018 tick SHALL be asserted in exactly the cycles where phase_tick=1 and phase_idx=NPHASE-1; period = NPHASE*D clocks.
REQ-019 With D=1, phase_tick SHALL be continuously high and tick high every NPHASE-th cycle.
REQ-020 All outputs SHALL be registered; no combinational path from input to output.
REQ-021 restart in RUN SHALL zero the cycle counter and phase index, reload div_act, and suppress any pulse due that cycle; the next phase_tick SHALL rise D clocks after the restart edge with phase_idx=0.
REQ-022 restart coinciding with a terminal count SHALL win; no pulse is emitted.
REQ-023 restart in IDLE SHALL be ignored.
REQ-024 en deasserted mid-period SHALL, at the next edge, return to IDLE, clear counters, force phase_tick/tick/busy to 0, and drop the pending pulse.
REQ-025 en re-asserted SHALL start a fresh period from phase 0 per REQ-016.
REQ-026 Counter arithmetic SHALL be unsigned DIV_W bits and never wrap past D-1.

Reset
REQ-027 reset_n=0 SHALL asynchronously set state=IDLE, counters=0, div_act=DEF_DIV, phase_tick=0, tick=0, phase_idx=0, busy=0.
REQ-028 Reset deasserted with en=1 SHALL behave as en rising at the first clk edge after release.
REQ-029 Reset asserted mid-period SHALL abort the period; no pulse is emitted after release until REQ-016 timing is met.

Structure
REQ-030 SHALL place the FSM state enum and the DEF_DIV/NPHASE defaults in shared package tick_pkg.
REQ-031 SHALL be a single module with no sub-modules; the counter and FSM live in one file.

Verification
REQ-032 D=62, NPHASE=4, en held high: phase_tick at E0+62, +124, +186, +248 with phase_idx 0,1,2,3; tick only at +248; repeats every 248 clocks.
REQ-033 div changed 62->10 mid-period: remaining phases of the current period stay 62 clocks; the next period uses 10 clocks per phase (tick period 40).
REQ-034 div=0 and div=1: phase_tick constantly 1; tick high every 4th cycle; phase_idx cycles 0..3.
REQ-035 restart asserted on the same edge as the phase-2 terminal count (D=5): no pulse that cycle; next pulse 5 clocks later with phase_idx=0.
REQ-036 en dropped at count 30 of D=62: next cycle busy=0 and all pulses 0; en high again gives first pulse 62 clocks later with phase_idx=0.
REQ-037 reset_n pulsed low asynchronously between clk edges while in RUN: outputs go to reset values immediately; div_act reads back as 62 on the next period.
